// File: rtl/fpu_queue_dispatcher_if.sv
// rtl/fpu_queue_dispatcher_if.sv - queue, memory-read and execution signals of the FPU dispatcher
interface fpu_queue_dispatcher_if;
  logic        queue_empty;
  logic [7:0]  q_opcode;
  logic [2:0]  q_stack_index;
  logic [19:0] q_ea;
  logic [1:0]  q_operand_size;
  logic        q_is_integer;
  logic        q_is_bcd;
  logic        q_has_memory_op;
  logic        q_has_pop;
  logic        dequeue;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        exec_valid;
  logic        exec_ready;
  logic [7:0]  exec_opcode;
  logic [2:0]  exec_stack_index;
  logic [1:0]  exec_operand_size;
  logic        exec_is_integer;
  logic        exec_is_bcd;
  logic        exec_has_pop;
  logic [79:0] exec_operand;
  logic        exec_mem_fault;
  logic        busy;

  modport master (
    input  queue_empty, q_opcode, q_stack_index, q_ea, q_operand_size,
           q_is_integer, q_is_bcd, q_has_memory_op, q_has_pop,
           mem_ack, mem_rdata, exec_ready,
    output dequeue, mem_req, mem_addr, exec_valid, exec_opcode, exec_stack_index,
           exec_operand_size, exec_is_integer, exec_is_bcd, exec_has_pop,
           exec_operand, exec_mem_fault, busy
  );

  modport slave (
    output queue_empty, q_opcode, q_stack_index, q_ea, q_operand_size,
           q_is_integer, q_is_bcd, q_has_memory_op, q_has_pop,
           mem_ack, mem_rdata, exec_ready,
    input  dequeue, mem_req, mem_addr, exec_valid, exec_opcode, exec_stack_index,
           exec_operand_size, exec_is_integer, exec_is_bcd, exec_has_pop,
           exec_operand, exec_mem_fault, busy
  );
endinterface

// File: rtl/fpu_queue_dispatcher.sv
// rtl/fpu_queue_dispatcher.sv - pops FPU queue head, fetches memory operand, issues to execution
// Optional fetch timeout enabled by defining FPU_DISPATCH_TIMEOUT_EN.
module fpu_queue_dispatcher #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  fpu_queue_dispatcher_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  state_t      state, state_nx;
  logic [19:0] ea_q;
  logic [2:0]  idx;
  logic [2:0]  last_idx;
  logic [79:0] operand;
  logic        fault_q;
  logic        timeout;

  always_comb begin
    last_idx = 3'd0;
    case (bus.exec_operand_size)
      2'd0: last_idx = 3'd0;
      2'd1: last_idx = 3'd1;
      2'd2: last_idx = 3'd3;
      2'd3: last_idx = 3'd4;
      default: last_idx = 3'd0;
    endcase
  end

`ifdef FPU_DISPATCH_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;

  assign timeout = (state == FETCH) && !bus.mem_ack &&
                   (tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || state != FETCH || bus.mem_ack)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_tmo_cfg;
  assign timeout        = 1'b0;
  assign unused_tmo_cfg = ^{TIMEOUT_W'(TIMEOUT_CYCLES)};
`endif

  // Reset gates the strobe so a non-empty queue is never popped while held in reset.
  assign bus.dequeue        = reset_n && (state == IDLE) && !bus.queue_empty;
  assign bus.mem_req        = (state == FETCH);
  assign bus.mem_addr       = ea_q + {16'd0, idx, 1'b0};
  assign bus.exec_valid     = (state == ISSUE);
  assign bus.exec_operand   = operand;
  assign bus.exec_mem_fault = fault_q;
  assign bus.busy           = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (!bus.queue_empty) state_nx = bus.q_has_memory_op ? FETCH : ISSUE;
      FETCH: if ((bus.mem_ack && idx == last_idx) || timeout) state_nx = ISSUE;
      ISSUE: if (bus.exec_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                 <= IDLE;
      ea_q                  <= '0;
      idx                   <= '0;
      operand               <= '0;
      fault_q               <= 1'b0;
      bus.exec_opcode       <= '0;
      bus.exec_stack_index  <= '0;
      bus.exec_operand_size <= '0;
      bus.exec_is_integer   <= 1'b0;
      bus.exec_is_bcd       <= 1'b0;
      bus.exec_has_pop      <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (!bus.queue_empty) begin
            ea_q                  <= bus.q_ea;
            idx                   <= '0;
            operand               <= '0;
            fault_q               <= 1'b0;
            bus.exec_opcode       <= bus.q_opcode;
            bus.exec_stack_index  <= bus.q_stack_index;
            bus.exec_operand_size <= bus.q_operand_size;
            bus.exec_is_integer   <= bus.q_is_integer;
            bus.exec_is_bcd       <= bus.q_is_bcd;
            bus.exec_has_pop      <= bus.q_has_pop;
          end
        end
        FETCH: begin
          if (bus.mem_ack) begin
            operand[{idx, 4'b0000} +: 16] <= bus.mem_rdata;
            if (idx != last_idx) idx <= idx + 3'd1;
          end else if (timeout) begin
            fault_q <= 1'b1;
          end
        end
        ISSUE: if (bus.exec_ready) fault_q <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
